// File: rtl/pcie_link_manager.sv
// PCIe bring-up and supervision FSM: synchronises PERST_n, sequences the hard-IP reset after PLL lock,
// waits for LTSSM L0 with timeout/retry, tracks lane width and link drops, and gates the application reset.
module pcie_link_manager #(
  parameter int NUM_LANES         = 4,
  parameter int RESET_HOLD_CYCLES = 1024,
  parameter int LINK_TIMEOUT      = 1 << 20,
  parameter int MAX_RETRIES       = 3,
  parameter int DROP_FILTER       = 16,
  parameter int APP_RST_DELAY     = 32,
  localparam int LW               = $clog2(NUM_LANES) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          perst_n_in,
  input  logic          pll_locked,
  input  logic [4:0]    ltssm_state,
  input  logic [LW-1:0] lanes_active,
  output logic          ip_rst_n,
  output logic          app_rst,
  output logic          link_up,
  output logic [LW-1:0] link_width,
  output logic          degraded,
  output logic [3:0]    retry_count,
  output logic [7:0]    drop_count,
  output logic          fail,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_TRAIN = 3'd2,
    ST_UP    = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam logic [4:0] LTSSM_L0 = 5'h0F;

  localparam int HOLD_W  = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int TRAIN_W = $clog2(LINK_TIMEOUT + 1);
  localparam int UP_W    = $clog2(APP_RST_DELAY + 1);
  localparam int FILT_W  = $clog2(DROP_FILTER + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(LINK_TIMEOUT - 1);
  localparam logic [UP_W-1:0]    UP_DONE    = UP_W'(APP_RST_DELAY);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(DROP_FILTER - 1);
  localparam logic [LW-1:0]      LANES_MAX  = LW'(NUM_LANES);
  localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TRAIN_W-1:0]  train_q, train_d;
  logic [UP_W-1:0]     up_q, up_d;
  logic [FILT_W-1:0]   filt_q, filt_d;
  logic [3:0]          retry_q, retry_d;
  logic [7:0]          drop_q, drop_d;
  logic [LW-1:0]       width_q, width_d;
  logic [LW-1:0]       lanes_clamped;
  logic                go, l0;
  logic                ip_rst_n_d, app_rst_d, link_up_d, degraded_d, fail_d;

  assign go            = sync_q[1] & pll_locked;
  assign l0            = (ltssm_state == LTSSM_L0);
  assign lanes_clamped = (lanes_active > LANES_MAX) ? LANES_MAX : lanes_active;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    train_d = '0;
    up_d    = '0;
    filt_d  = '0;
    retry_d = retry_q;
    drop_d  = drop_q;
    width_d = width_q;

    // Losing PERST or PLL lock aborts any attempt; counters restart from zero on every state entry.
    if (!go && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      retry_d = '0;
      if (state_q == ST_UP && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else begin
      case (state_q)
        ST_IDLE: if (go) state_d = ST_HOLD;
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) state_d = ST_TRAIN;
          else                     hold_d  = hold_q + 1'b1;
        end
        ST_TRAIN: begin
          if (l0) begin
            state_d = ST_UP;
            width_d = lanes_clamped;
            retry_d = '0;
          end else if (train_q == TRAIN_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            train_d = train_q + 1'b1;
          end
        end
        ST_UP: begin
          up_d = (up_q == UP_DONE) ? up_q : up_q + 1'b1;
          if (!l0) begin
            if (filt_q == FILT_LAST) begin
              state_d = ST_HOLD;
              if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
              filt_d = filt_q + 1'b1;
            end
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end

    ip_rst_n_d = (state_d == ST_TRAIN) || (state_d == ST_UP);
    link_up_d  = (state_d == ST_UP);
    app_rst_d  = !(link_up_d && up_d == UP_DONE);
    degraded_d = link_up_d && (width_d < LANES_MAX);
    fail_d     = (state_d == ST_FAIL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= '0;
      hold_q      <= '0;
      train_q     <= '0;
      up_q        <= '0;
      filt_q      <= '0;
      retry_q     <= '0;
      drop_q      <= '0;
      width_q     <= '0;
      ip_rst_n    <= 1'b0;
      app_rst     <= 1'b1;
      link_up     <= 1'b0;
      degraded    <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], perst_n_in};
      hold_q      <= hold_d;
      train_q     <= train_d;
      up_q        <= up_d;
      filt_q      <= filt_d;
      retry_q     <= retry_d;
      drop_q      <= drop_d;
      width_q     <= width_d;
      ip_rst_n    <= ip_rst_n_d;
      app_rst     <= app_rst_d;
      link_up     <= link_up_d;
      degraded    <= degraded_d;
      fail        <= fail_d;
    end
  end

  assign state       = state_q;
  assign retry_count = retry_q;
  assign drop_count  = drop_q;
  assign link_width  = width_q;

endmodule

// File: tb/tb_pcie_link_manager.sv
// Bench for pcie_link_manager: directed bring-up/retry/drop/degrade/reset scenarios followed by random
// input traffic, every cycle compared against a phase/age reference model of the link manager.
module tb_pcie_link_manager;

  localparam int NUM_LANES         = 4;
  localparam int RESET_HOLD_CYCLES = 8;
  localparam int LINK_TIMEOUT      = 100;
  localparam int MAX_RETRIES       = 2;
  localparam int DROP_FILTER       = 4;
  localparam int APP_RST_DELAY     = 5;
  localparam int LW                = $clog2(NUM_LANES) + 1;

  localparam int P_IDLE = 0, P_HOLD = 1, P_TRAIN = 2, P_UP = 3, P_FAIL = 4;
  localparam logic [4:0] L0 = 5'h0F;

  logic          clk = 1'b0;
  logic          reset;
  logic          perst_n_in;
  logic          pll_locked;
  logic [4:0]    ltssm_state;
  logic [LW-1:0] lanes_active;
  logic          ip_rst_n;
  logic          app_rst;
  logic          link_up;
  logic [LW-1:0] link_width;
  logic          degraded;
  logic [3:0]    retry_count;
  logic [7:0]    drop_count;
  logic          fail;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase plus how long it has lasted, in plain integers.
  int m_phase = P_IDLE;
  int m_sync1 = 0, m_sync2 = 0;
  int m_hold_age = 0, m_train_age = 0, m_up_age = 0, m_bad_run = 0;
  int m_retries = 0, m_drops = 0, m_width = 0;

  pcie_link_manager #(
    .NUM_LANES        (NUM_LANES),
    .RESET_HOLD_CYCLES(RESET_HOLD_CYCLES),
    .LINK_TIMEOUT     (LINK_TIMEOUT),
    .MAX_RETRIES      (MAX_RETRIES),
    .DROP_FILTER      (DROP_FILTER),
    .APP_RST_DELAY    (APP_RST_DELAY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .perst_n_in  (perst_n_in),
    .pll_locked  (pll_locked),
    .ltssm_state (ltssm_state),
    .lanes_active(lanes_active),
    .ip_rst_n    (ip_rst_n),
    .app_rst     (app_rst),
    .link_up     (link_up),
    .link_width  (link_width),
    .degraded    (degraded),
    .retry_count (retry_count),
    .drop_count  (drop_count),
    .fail        (fail),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic count_drop();
    if (m_drops < 255) m_drops++;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit go, is_l0;
    if (reset) begin
      m_phase = P_IDLE; m_sync1 = 0; m_sync2 = 0;
      m_hold_age = 0; m_train_age = 0; m_up_age = 0; m_bad_run = 0;
      m_retries = 0; m_drops = 0; m_width = 0;
      return;
    end
    go      = (m_sync2 != 0) && pll_locked;
    m_sync2 = m_sync1;
    m_sync1 = perst_n_in;
    is_l0   = (ltssm_state == L0);
    if (!go && m_phase != P_IDLE) begin
      if (m_phase == P_UP) count_drop();
      m_phase   = P_IDLE;
      m_retries = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (go) begin m_phase = P_HOLD; m_hold_age = 0; end
      P_HOLD: begin
        m_hold_age++;
        if (m_hold_age == RESET_HOLD_CYCLES) begin m_phase = P_TRAIN; m_train_age = 0; end
      end
      P_TRAIN: begin
        m_train_age++;
        if (is_l0) begin
          m_phase = P_UP; m_up_age = 0; m_bad_run = 0; m_retries = 0;
          m_width = (lanes_active > NUM_LANES) ? NUM_LANES : int'(lanes_active);
        end else if (m_train_age == LINK_TIMEOUT) begin
          if (m_retries < MAX_RETRIES) begin
            m_retries++; m_phase = P_HOLD; m_hold_age = 0;
          end else begin
            m_phase = P_FAIL;
          end
        end
      end
      P_UP: begin
        m_up_age++;
        if (is_l0) m_bad_run = 0;
        else begin
          m_bad_run++;
          if (m_bad_run == DROP_FILTER) begin
            count_drop(); m_phase = P_HOLD; m_hold_age = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("state",       state,       m_phase);
    check("ip_rst_n",    ip_rst_n,    (m_phase == P_TRAIN || m_phase == P_UP));
    check("app_rst",     app_rst,     !(m_phase == P_UP && m_up_age >= APP_RST_DELAY));
    check("link_up",     link_up,     (m_phase == P_UP));
    check("link_width",  link_width,  m_width);
    check("degraded",    degraded,    (m_phase == P_UP && m_width < NUM_LANES));
    check("retry_count", retry_count, m_retries);
    check("drop_count",  drop_count,  m_drops);
    check("fail",        fail,        (m_phase == P_FAIL));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic tick_until_up();
    for (int k = 0; k < 20 && m_phase != P_UP; k++) tick(1);
  endtask

  initial begin
    reset = 1'b1; perst_n_in = 1'b0; pll_locked = 1'b0; ltssm_state = 5'h00; lanes_active = 3'd4;
    tick(3);
    check("rst_state",    state,       3'd0);
    check("rst_ip_rst_n", ip_rst_n,    1'b0);
    check("rst_app_rst",  app_rst,     1'b1);
    check("rst_drop",     drop_count,  8'd0);
    reset = 1'b0;
    tick(2);

    // Bring-up: L0 arrives in the 20th TRAIN cycle with four lanes.
    perst_n_in = 1'b1; pll_locked = 1'b1;
    tick(3);
    check("s1_hold_entry", state, 3'd1);
    tick(7);
    check("s1_hold_ip_rst", ip_rst_n, 1'b0);
    tick(1);
    check("s1_train_ip_rst", ip_rst_n, 1'b1);
    tick(19);
    check("s1_train_wait", link_up, 1'b0);
    ltssm_state = L0;
    tick(1);
    check("s1_link_up", link_up, 1'b1);
    check("s1_app_rst_held", app_rst, 1'b1);
    check("s1_width", link_width, 3'd4);
    check("s1_degraded", degraded, 1'b0);
    tick(4);
    check("s1_app_rst_4", app_rst, 1'b1);
    tick(1);
    check("s1_app_rst_rel", app_rst, 1'b0);

    // Drop filter: a 3-cycle glitch is ignored, 4 cycles declare a drop.
    ltssm_state = 5'h00;
    tick(3);
    check("s3_glitch_state", state, 3'd3);
    ltssm_state = L0;
    tick(1);
    ltssm_state = 5'h00;
    tick(4);
    check("s3_drop_state", state, 3'd1);
    check("s3_drop_count", drop_count, 8'd1);
    check("s3_drop_app_rst", app_rst, 1'b1);
    check("s3_drop_link_up", link_up, 1'b0);

    // Degraded and clamped widths.
    ltssm_state = L0; lanes_active = 3'd2;
    tick(9);
    check("s4_width2", link_width, 3'd2);
    check("s4_degraded", degraded, 1'b1);
    ltssm_state = 5'h00;
    tick(4);
    ltssm_state = L0; lanes_active = 3'd7;
    tick(9);
    check("s4_clamp", link_width, 3'd4);
    check("s4_not_degraded", degraded, 1'b0);

    // PLL loss mid-TRAIN, then L0 exactly on the timeout cycle.
    ltssm_state = 5'h00;
    tick(4);
    tick(8);
    tick(10);
    pll_locked = 1'b0;
    tick(1);
    check("s5_pll_idle", state, 3'd0);
    check("s5_pll_ip_rst", ip_rst_n, 1'b0);
    pll_locked = 1'b1;
    tick(1);
    check("s5_rehold", state, 3'd1);
    tick(8);
    tick(99);
    ltssm_state = L0;
    tick(1);
    check("s5_timeout_l0", state, 3'd3);
    check("s5_no_retry", retry_count, 4'd0);

    // Timeouts: two retries, then FAIL until PERST asserts.
    ltssm_state = 5'h00;
    tick(4);
    for (int r = 1; r <= MAX_RETRIES; r++) begin
      tick(8 + LINK_TIMEOUT);
      check("s2_retry", retry_count, 4'(r));
      check("s2_retry_hold", state, 3'd1);
    end
    tick(8 + LINK_TIMEOUT);
    check("s2_fail", fail, 1'b1);
    check("s2_fail_ip_rst", ip_rst_n, 1'b0);
    perst_n_in = 1'b0;
    tick(2);
    check("s2_fail_sticky", fail, 1'b1);
    tick(1);
    check("s2_idle", state, 3'd0);
    check("s2_fail_clr", fail, 1'b0);
    check("s2_retry_clr", retry_count, 4'd0);

    // Saturate drop_count, then reset from UP.
    perst_n_in = 1'b1;
    for (int d = 0; d < 300 && m_drops < 255; d++) begin
      ltssm_state = L0;
      tick_until_up();
      ltssm_state = 5'h00;
      tick(4);
    end
    check("s6_drop_255", drop_count, 8'd255);
    ltssm_state = L0;
    tick_until_up();
    ltssm_state = 5'h00;
    tick(4);
    check("s6_drop_sat", drop_count, 8'd255);
    ltssm_state = L0;
    tick_until_up();
    tick(2);
    check("s6_up", state, 3'd3);
    reset = 1'b1;
    tick(1);
    check("s6_rst_state",    state,       3'd0);
    check("s6_rst_ip_rst_n", ip_rst_n,    1'b0);
    check("s6_rst_app_rst",  app_rst,     1'b1);
    check("s6_rst_link_up",  link_up,     1'b0);
    check("s6_rst_width",    link_width,  3'd0);
    check("s6_rst_degraded", degraded,    1'b0);
    check("s6_rst_retry",    retry_count, 4'd0);
    check("s6_rst_drop",     drop_count,  8'd0);
    check("s6_rst_fail",     fail,        1'b0);
    reset = 1'b0;

    // Random traffic against the model.
    begin
      bit want_l0;
      int v;
      want_l0 = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        reset = ($urandom_range(0, 499) == 0);
        if (perst_n_in) perst_n_in = ($urandom_range(0, 199) != 0);
        else            perst_n_in = ($urandom_range(0, 9) == 0);
        pll_locked = ($urandom_range(0, 149) != 0);
        if ($urandom_range(0, 19) == 0) want_l0 = ~want_l0;
        v = $urandom_range(0, 31);
        if (v == 15) v = 0;
        ltssm_state  = want_l0 ? L0 : 5'(v);
        lanes_active = 3'($urandom_range(0, 7));
        tick(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
